// File: rtl/mux4_scan_sampler_pkg.sv
// Shared definitions for the MUX4 round-robin scan sampler: channel count,
// select width, scan FSM encoding and the event record layout.
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [SEL_W-1:0] chan;
      logic             level;
   } evt_t;

   // Next channel in the round-robin; channel 3 wraps back to channel 0.
   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] sel);
      return sel + 2'd1;
   endfunction

endpackage

// File: rtl/mux4_scan_sampler_if.sv
// Bundle of the scan-control, debounced-level and event handshake signals.
// The slave modport is the sampler's view; the master modport is the
// surrounding logic (MUX4 plus the event consumer).
interface mux4_scan_sampler_if;
   import mux_scan_pkg::*;

   logic             en;
   logic [SEL_W-1:0] sel;
   logic             mux_out;
   logic [NUM_CH-1:0] state;
   logic             evt_valid;
   logic             evt_ready;
   logic [SEL_W-1:0] evt_chan;
   logic             evt_level;
   logic             overrun;
   logic             ovr_clr;

   modport slave (
      input  en, mux_out, evt_ready, ovr_clr,
      output sel, state, evt_valid, evt_chan, evt_level, overrun
   );

   modport master (
      output en, mux_out, evt_ready, ovr_clr,
      input  sel, state, evt_valid, evt_chan, evt_level, overrun
   );
endinterface

// File: rtl/mux4_scan_sampler_debounce.sv
// Per-channel debouncer. Counts consecutive captures that disagree with the
// accepted level; the DEBOUNCE-th one flips the level. flip_o is a same-cycle
// pulse so the parent can register the event on the accepting edge.
module chan_debounce #(
   parameter int DEBOUNCE = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cap_i,
   input  logic sample_i,
   input  logic clr_i,
   output logic level_o,
   output logic flip_o
);
   localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

   logic [3:0] cnt_q, cnt_d, cnt_inc_s;
   logic       level_q, level_d;

   // Counter and level next-state; clear wins over a capture.
   always_comb begin
      cnt_inc_s = cnt_q + 4'd1;
      cnt_d     = cnt_q;
      level_d   = level_q;
      flip_o    = 1'b0;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (cap_i) begin
         if (sample_i == level_q) begin
            cnt_d = 4'd0;
         end else if (cnt_inc_s == DB_LIMIT) begin
            cnt_d   = 4'd0;
            level_d = ~level_q;
            flip_o  = 1'b1;
         end else begin
            cnt_d = cnt_inc_s;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 4'd0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
endmodule

// File: rtl/mux4_scan_sampler.sv
// Round-robin scanner in front of MUX4: drives sel, waits the settle time,
// captures mux_out for the selected channel, debounces per channel and
// reports accepted level changes through a one-entry valid/ready register.
module mux4_scan_sampler
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int DEBOUNCE      = 3
) (
   input logic clk,
   input logic rst_n,
   mux4_scan_sampler_if.slave bus
);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   scan_state_e       state_q, state_d;
   logic [7:0]        settle_q, settle_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              cap_s;
   logic              clr_s;
   logic [NUM_CH-1:0] flip_s;
   logic [NUM_CH-1:0] level_s;
   logic              flip_any_s;
   evt_t              new_evt_s;
   evt_t              evt_q, evt_d;
   logic              evt_valid_q, evt_valid_d;
   logic              ovr_q, ovr_d;

   // Scan FSM next-state, settle countdown and select advance.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      sel_d    = sel_q;
      cap_s    = 1'b0;
      if (!bus.en) begin
         state_d  = IDLE;
         settle_d = 8'd0;
         sel_d    = {SEL_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
            SETTLE: begin
               if (settle_q == 8'd0) begin
                  state_d = SAMPLE;
               end else begin
                  settle_d = settle_q - 8'd1;
               end
            end
            SAMPLE: begin
               cap_s    = 1'b1;
               sel_d    = sel_inc(sel_q);
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
            default: begin
               state_d  = IDLE;
               settle_d = 8'd0;
               sel_d    = {SEL_W{1'b0}};
            end
         endcase
      end
   end

   // Scan FSM, settle counter and select registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         settle_q <= 8'd0;
         sel_q    <= {SEL_W{1'b0}};
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         sel_q    <= sel_d;
      end
   end

   // Dropping enable abandons any partial debounce progress.
   assign clr_s = ~bus.en;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      chan_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .cap_i    (cap_s && (sel_q == SEL_W'(g))),
         .sample_i (bus.mux_out),
         .clr_i    (clr_s),
         .level_o  (level_s[g]),
         .flip_o   (flip_s[g])
      );
   end

   // Event register and sticky overrun next-state; a new event may replace
   // one that is leaving in the same cycle, otherwise it is dropped.
   always_comb begin
      flip_any_s      = |flip_s;
      new_evt_s.chan  = sel_q;
      new_evt_s.level = ~level_s[sel_q];
      evt_d           = evt_q;
      evt_valid_d     = evt_valid_q;
      ovr_d           = ovr_q;
      if (flip_any_s && (!evt_valid_q || bus.evt_ready)) begin
         evt_d       = new_evt_s;
         evt_valid_d = 1'b1;
      end else if (evt_valid_q && bus.evt_ready) begin
         evt_valid_d = 1'b0;
      end else begin
         evt_valid_d = evt_valid_q;
      end
      if (flip_any_s && evt_valid_q && !bus.evt_ready) begin
         ovr_d = 1'b1;
      end else if (bus.ovr_clr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Event and overrun registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q       <= '{chan: {SEL_W{1'b0}}, level: 1'b0};
         evt_valid_q <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         evt_q       <= evt_d;
         evt_valid_q <= evt_valid_d;
         ovr_q       <= ovr_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.state     = level_s;
   assign bus.evt_valid = evt_valid_q;
   assign bus.evt_chan  = evt_q.chan;
   assign bus.evt_level = evt_q.level;
   assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_mux4_scan_sampler.sv
// Directed bench for mux4_scan_sampler (SETTLE_CYCLES=2, DEBOUNCE=3).
// Expected events are queued by the stimulus; a monitor forked alongside
// pops and compares on every valid&ready transfer.
module tb_mux4_scan_sampler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] chan_lvl = 4'b0000;
   int vectors = 0;
   int miscompares = 0;
   int e = 0;
   logic [2:0] exp_q [$];

   mux4_scan_sampler_if bus_if ();

   mux4_scan_sampler #(.SETTLE_CYCLES(2), .DEBOUNCE(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // Behavioural MUX4: selected channel level back into the sampler.
   assign bus_if.mux_out = chan_lvl[bus_if.sel];

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge k+%0d)", name, act, exp, e);
      end
   endtask

   // Advance to just after edge k+target.
   task automatic go_to(input int target);
      while (e < target) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   // Reset, load channel levels and ready, then raise en so the next edge is k.
   task automatic restart(input logic [3:0] lv, input logic rdy);
      bus_if.en        = 1'b0;
      rst_n            = 1'b0;
      chan_lvl         = lv;
      bus_if.evt_ready = rdy;
      bus_if.ovr_clr   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_if.en = 1'b1;
      e = -1;
   endtask

   initial begin
      bus_if.en        = 1'b0;
      bus_if.evt_ready = 1'b0;
      bus_if.ovr_clr   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n && bus_if.evt_valid && bus_if.evt_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL evt_unexpected: got chan %0d level %0d expected none",
                           bus_if.evt_chan, bus_if.evt_level);
               end else begin
                  chk("evt_transfer", int'({bus_if.evt_chan, bus_if.evt_level}),
                      int'(exp_q.pop_front()));
               end
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // 1: select sequence, no events, all low
      restart(4'b0000, 1'b1);
      chk("rst_sel", int'(bus_if.sel), 0);
      chk("rst_state", int'(bus_if.state), 0);
      chk("rst_valid", int'(bus_if.evt_valid), 0);
      chk("rst_ovr", int'(bus_if.overrun), 0);
      go_to(2);  chk("sel_k2", int'(bus_if.sel), 0);
      go_to(3);  chk("sel_k3", int'(bus_if.sel), 1);
      go_to(5);  chk("sel_k5", int'(bus_if.sel), 1);
      go_to(6);  chk("sel_k6", int'(bus_if.sel), 2);
      go_to(9);  chk("sel_k9", int'(bus_if.sel), 3);
      go_to(11); chk("sel_k11", int'(bus_if.sel), 3);
      go_to(12); chk("sel_k12", int'(bus_if.sel), 0);
      chk("t1_state", int'(bus_if.state), 0);
      chk("t1_valid", int'(bus_if.evt_valid), 0);

      // 2: channel 2 held high, flips at k+33
      restart(4'b0100, 1'b1);
      exp_q.push_back({2'd2, 1'b1});
      go_to(32);
      chk("t2_state_pre", int'(bus_if.state), 0);
      chk("t2_valid_pre", int'(bus_if.evt_valid), 0);
      go_to(33);
      chk("t2_state", int'(bus_if.state), 4'b0100);
      chk("t2_valid", int'(bus_if.evt_valid), 1);
      chk("t2_chan", int'(bus_if.evt_chan), 2);
      chk("t2_level", int'(bus_if.evt_level), 1);
      go_to(34);
      chk("t2_valid_after", int'(bus_if.evt_valid), 0);

      // 3: channel 1 glitches high for two captures, twice
      chan_lvl[1] = 1'b1;
      go_to(54); chk("t3_state_a", int'(bus_if.state), 4'b0100);
      go_to(55); chan_lvl[1] = 1'b0;
      go_to(66); chk("t3_state_b", int'(bus_if.state), 4'b0100);
      chan_lvl[1] = 1'b1;
      go_to(90);
      chk("t3_state_c", int'(bus_if.state), 4'b0100);
      chk("t3_valid", int'(bus_if.evt_valid), 0);
      chan_lvl[1] = 1'b0;

      // 4: ready low, ch0 then ch3 flip; second dropped, overrun
      restart(4'b1001, 1'b0);
      go_to(27);
      chk("t4_valid_a", int'(bus_if.evt_valid), 1);
      chk("t4_chan_a", int'(bus_if.evt_chan), 0);
      chk("t4_state_a", int'(bus_if.state), 4'b0001);
      go_to(35); chk("t4_ovr_pre", int'(bus_if.overrun), 0);
      go_to(36);
      chk("t4_state", int'(bus_if.state), 4'b1001);
      chk("t4_valid", int'(bus_if.evt_valid), 1);
      chk("t4_chan_held", int'(bus_if.evt_chan), 0);
      chk("t4_level_held", int'(bus_if.evt_level), 1);
      chk("t4_ovr", int'(bus_if.overrun), 1);
      bus_if.ovr_clr = 1'b1;
      go_to(37);
      chk("t4_ovr_clr", int'(bus_if.overrun), 0);
      bus_if.ovr_clr = 1'b0;
      exp_q.push_back({2'd0, 1'b1});
      bus_if.evt_ready = 1'b1;
      go_to(38);
      chk("t4_valid_drain", int'(bus_if.evt_valid), 0);

      // 5: transfer and reload on the same edge, no bubble
      restart(4'b1001, 1'b0);
      go_to(35);
      chk("t5_chan_a", int'(bus_if.evt_chan), 0);
      exp_q.push_back({2'd0, 1'b1});
      exp_q.push_back({2'd3, 1'b1});
      bus_if.evt_ready = 1'b1;
      go_to(36);
      chk("t5_valid", int'(bus_if.evt_valid), 1);
      chk("t5_chan_b", int'(bus_if.evt_chan), 3);
      chk("t5_level_b", int'(bus_if.evt_level), 1);
      chk("t5_ovr", int'(bus_if.overrun), 0);
      go_to(37);
      chk("t5_valid_end", int'(bus_if.evt_valid), 0);

      // 6a: asynchronous reset mid-SETTLE with an event held
      restart(4'b0001, 1'b0);
      go_to(28);
      chk("t6_state_pre", int'(bus_if.state), 4'b0001);
      chk("t6_sel_pre", int'(bus_if.sel), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_sel", int'(bus_if.sel), 0);
      chk("t6_async_state", int'(bus_if.state), 0);
      chk("t6_async_valid", int'(bus_if.evt_valid), 0);
      chk("t6_async_chan", int'(bus_if.evt_chan), 0);
      chk("t6_async_level", int'(bus_if.evt_level), 0);
      chk("t6_async_ovr", int'(bus_if.overrun), 0);

      // 6b: en dropped mid-scan; state kept, debounce progress lost
      restart(4'b0011, 1'b1);
      exp_q.push_back({2'd0, 1'b1});
      go_to(28);
      bus_if.en = 1'b0;
      go_to(29);
      chk("t6_en_sel", int'(bus_if.sel), 0);
      chk("t6_en_state", int'(bus_if.state), 4'b0001);
      bus_if.en = 1'b1;
      e = -1;
      go_to(2); chk("t6_re_sel2", int'(bus_if.sel), 0);
      go_to(3); chk("t6_re_sel3", int'(bus_if.sel), 1);
      go_to(6); chk("t6_re_state6", int'(bus_if.state), 4'b0001);
      exp_q.push_back({2'd1, 1'b1});
      go_to(29); chk("t6_re_state29", int'(bus_if.state), 4'b0001);
      go_to(30);
      chk("t6_re_state30", int'(bus_if.state), 4'b0011);
      chk("t6_re_chan", int'(bus_if.evt_chan), 1);
      go_to(32);

      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mux4_scan_sampler.md
# mux4_scan_sampler

Round-robin scanner that sits directly upstream of the 4:1 channel multiplexer (MUX4). It drives the mux select, waits a programmable settle time, samples the single-bit mux output, and debounces each of the four channels independently. Debounced channel levels are exposed as a 4-bit vector. Each accepted level change is reported as a one-entry valid/ready event to downstream logic.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles held after a select change before sampling; legal range 1..255
- DEBOUNCE, 3, consecutive differing samples required to accept a new level; legal range 1..15

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- sel  out  2  channel select driven to MUX4 sel
- mux_out  in  1  MUX4 out, the selected channel
- state  out  4  debounced level per channel; bit n corresponds to channel n
- evt_valid  out  1  event pending
- evt_ready  in  1  downstream accepts the event
- evt_chan  out  2  channel that changed
- evt_level  out  1  new debounced level
- overrun  out  1  sticky flag: an event was dropped
- ovr_clr  in  1  clears overrun

## Operation
- FSM states:
  - IDLE: sel=0, counters cleared. Goes to SETTLE when en=1.
  - SETTLE: settle counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. Goes to SAMPLE when the counter is 0.
  - SAMPLE: lasts one cycle. The closing edge captures mux_out for channel sel, then sel ← sel+1 (3 wraps to 0) and the FSM returns to SETTLE.
- en=0 in any state: the next edge goes to IDLE. sel→0, settle and debounce counters cleared. state, the pending event and overrun are retained.
- Debounce, per channel, at each capture for that channel:
  - Sample equals state[ch]: the channel counter clears.
  - Sample differs: the counter increments.
  - When the counter would reach DEBOUNCE: state[ch] flips, the counter clears, and an event {ch, new level} is generated.
  - With DEBOUNCE=1, a single differing sample flips the level.
- Event register, one entry:
  - Load when evt_valid=0, or when evt_valid=1 and evt_ready=1 in the same cycle (back-to-back transfer, no bubble).
  - evt_valid=1 with evt_ready=0 and a new event: the new event is dropped, the held event stays unchanged, and overrun is set. state is still updated.
  - evt_chan and evt_level stay stable while evt_valid=1 and evt_ready=0.
- overrun: ovr_clr clears it. A set and a clear in the same cycle resolve to set.
- Only one channel is captured per cycle, so at most one event is generated per cycle.

## Timing
- Reset values: sel=0, state=4'b0000, evt_valid=0, evt_chan=0, evt_level=0, overrun=0, FSM=IDLE, all counters 0.
- Reset asserts asynchronously at any point mid-scan. Release is synchronous to clk.
- en seen high in IDLE at edge k:
  - First capture (ch0) occurs at edge k+SETTLE_CYCLES+1.
  - Per-channel period is SETTLE_CYCLES+1 cycles.
  - Full scan is 4×(SETTLE_CYCLES+1) cycles.
- sel changes only on the SAMPLE-closing edge. sel is registered, with no combinational path from mux_out.
- state[ch] and evt_valid update on the same edge as the accepting capture: 0 cycles of added latency after the DEBOUNCE-th capture.
- Worst-case detection latency: DEBOUNCE full scans plus one channel period.

## Structure
- Shared package mux_scan_pkg holds:
  - NUM_CH=4 and SEL_W=2
  - FSM state encoding (IDLE, SETTLE, SAMPLE) as a typedef
  - Event record layout (chan, level)
- One sub-module, chan_debounce, instantiated four times. Inputs are capture strobe, sample and clear. Outputs are the level and a flip pulse. Counter width is 4 bits.
- The top level contains the FSM, the settle counter, select generation, the event register and overrun.

## Test plan
All scenarios use SETTLE_CYCLES=2 and DEBOUNCE=3.
1. Reset then en=1 at edge k, mux_out=0 → sel sequence 0,1,2,3,0 changing at edges k+3, k+6, k+9, k+12; no events; state=0000.
2. Channel 2 held at 1 from start → ch2 captures at edges k+9, k+21, k+33; state[2]=1 at k+33 with evt_valid=1, evt_chan=2, evt_level=1.
3. Channel 1 glitch high for 2 consecutive captures, then low → state[1] stays 0; no event.
4. evt_ready=0, ch0 then ch3 both flip → first event held; second dropped; overrun=1; state=1001. ovr_clr pulse → overrun=0. evt_ready=1 → held event transfers.
5. evt_ready=1 with events accepted in consecutive cycles → no bubble; evt_valid stays 1; chan/level update each transfer.
6. Reset asserted mid-SETTLE and en dropped mid-scan → all outputs at reset values asynchronously. For en=0: sel=0 and IDLE at the next edge; state retained; debounce progress cleared.
